// File: rtl/robot_drive_ctrl.sv
// Drive controller for the light-following robot: steer filter, manual drive, bump recovery.
// Optional dark-search spin is compiled in with ROBOT_DRIVE_SEARCH_EN.
module robot_drive_ctrl #(
    parameter int BACKUP_CYC = 50,
    parameter int TURN_CYC   = 30,
    parameter int STABLE_CYC = 4,
    parameter int DARK_CYC   = 100,
    parameter int CW         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [2:0] sens_l,
    input  logic [2:0] sens_r,
    input  logic       man_mode,
    input  logic       man_l,
    input  logic       man_r,
    input  logic       bump,
    output logic       lw,
    output logic       rw,
    output logic       lrev,
    output logic       rrev,
    output logic [2:0] state,
    output logic [6:0] hex_l,
    output logic [6:0] hex_r
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TRACK  = 3'd1,
        MANUAL = 3'd2,
        BACKUP = 3'd3,
        TURN   = 3'd4,
        SEARCH = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ST_BOTH  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } steer_t;

`ifdef ROBOT_DRIVE_SEARCH_EN
    localparam bit SEARCH_EN = 1'b1;
`else
    localparam bit SEARCH_EN = 1'b0;
`endif

    localparam logic [6:0] SEG_F = 7'b0001110;
    localparam logic [6:0] SEG_S = 7'b0010010;
    localparam logic [6:0] SEG_R = 7'b0101111;

    localparam int SW = $clog2(STABLE_CYC + 1);
    localparam int DW = $clog2(DARK_CYC + 1);

    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYC - 1);
    localparam logic [DW-1:0] DARK_LAST   = DW'(DARK_CYC - 1);
    localparam logic [CW-1:0] BACKUP_LD   = CW'(BACKUP_CYC - 1);
    localparam logic [CW-1:0] TURN_LD     = CW'(TURN_CYC - 1);

    state_t        st;
    state_t        nst;
    steer_t        steer;
    steer_t        raw;
    logic          dark;
    logic [SW-1:0] srun;
    logic [DW-1:0] dcnt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] ncnt;
    logic          turn_left;
    logic          nleft;
    logic          nlw;
    logic          nrw;
    logic          nlrev;
    logic          nrrev;

    function automatic logic [6:0] seg(input logic fwd, input logic rev);
        if (fwd)
            seg = SEG_F;
        else if (rev)
            seg = SEG_R;
        else
            seg = SEG_S;
    endfunction

    // Raw steer decision from the two sensor banks
    always_comb begin
        dark = (sens_l == 3'd0) && (sens_r == 3'd0);
        raw  = ST_BOTH;
        if (sens_l > sens_r)
            raw = ST_LEFT;
        else if (sens_r > sens_l)
            raw = ST_RIGHT;
    end

    // Steer filter: adopt a new decision only after it persists
    always_ff @(posedge clk) begin
        if (reset) begin
            steer <= ST_BOTH;
            srun  <= '0;
        end else if (dark || raw == steer) begin
            srun <= '0;
        end else if (srun == STABLE_LAST) begin
            steer <= raw;
            srun  <= '0;
        end else begin
            srun <= srun + 1'b1;
        end
    end

    // Wheel drive for the present state
    always_comb begin
        nlw   = 1'b0;
        nrw   = 1'b0;
        nlrev = 1'b0;
        nrrev = 1'b0;
        if (run) begin
            case (st)
                TRACK: begin
                    if (!dark) begin
                        nlw = (steer != ST_LEFT);
                        nrw = (steer != ST_RIGHT);
                    end
                end
                MANUAL: begin
                    nlw = man_l;
                    nrw = man_r;
                end
                BACKUP: begin
                    nlrev = 1'b1;
                    nrrev = 1'b1;
                end
                TURN: begin
                    nlw   = !turn_left;
                    nrrev = !turn_left;
                    nrw   = turn_left;
                    nlrev = turn_left;
                end
                SEARCH: begin
                    nlw   = SEARCH_EN;
                    nrrev = SEARCH_EN;
                end
                default: ;
            endcase
        end
    end

    // Next state, manoeuvre counter and turn direction
    always_comb begin
        nst   = st;
        ncnt  = '0;
        nleft = turn_left;
        if (!run) begin
            nst = IDLE;
        end else begin
            case (st)
                IDLE: nst = TRACK;
                TRACK: begin
                    if (bump) begin
                        nst   = BACKUP;
                        ncnt  = BACKUP_LD;
                        nleft = (steer == ST_LEFT);
                    end else if (man_mode) begin
                        nst = MANUAL;
                    end else if (SEARCH_EN && dark && dcnt == DARK_LAST) begin
                        nst = SEARCH;
                    end
                end
                MANUAL: begin
                    if (bump) begin
                        nst   = BACKUP;
                        ncnt  = BACKUP_LD;
                        nleft = (steer == ST_LEFT);
                    end else if (!man_mode) begin
                        nst = TRACK;
                    end
                end
                BACKUP: begin
                    if (cnt == '0) begin
                        nst  = TURN;
                        ncnt = TURN_LD;
                    end else begin
                        ncnt = cnt - 1'b1;
                    end
                end
                TURN: begin
                    if (cnt == '0)
                        nst = man_mode ? MANUAL : TRACK;
                    else
                        ncnt = cnt - 1'b1;
                end
                SEARCH: begin
                    if (SEARCH_EN && bump) begin
                        nst   = BACKUP;
                        ncnt  = BACKUP_LD;
                        nleft = (steer == ST_LEFT);
                    end else if (!dark || !SEARCH_EN) begin
                        nst = TRACK;
                    end
                end
                default: nst = IDLE;
            endcase
        end
    end

    // Consecutive dark cycles while tracking
    always_ff @(posedge clk) begin
        if (reset)
            dcnt <= '0;
        else if (st == TRACK && nst == TRACK && dark)
            dcnt <= (dcnt == DARK_LAST) ? dcnt : dcnt + 1'b1;
        else
            dcnt <= '0;
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= IDLE;
            cnt       <= '0;
            turn_left <= 1'b0;
            lw        <= 1'b0;
            rw        <= 1'b0;
            lrev      <= 1'b0;
            rrev      <= 1'b0;
            hex_l     <= SEG_S;
            hex_r     <= SEG_S;
        end else begin
            st        <= nst;
            cnt       <= ncnt;
            turn_left <= nleft;
            lw        <= nlw;
            rw        <= nrw;
            lrev      <= nlrev;
            rrev      <= nrrev;
            hex_l     <= seg(nlw, nlrev);
            hex_r     <= seg(nrw, nrrev);
        end
    end

    assign state = st;

endmodule
